serial_adder: RTL and testbench

- Bit-serial W-bit adder: accepts two operand words over a valid/ready handshake and adds them LSB-first, one bit per clock.
- Per-bit datapath: two half adders plus an OR form a full adder; a single registered carry links the bits.
- Returns the W-bit sum and the carry-out over a second valid/ready handshake.
- Sits downstream of operand producers and trades latency for area against a parallel ripple adder.

---
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial W-bit adder, LSB first, one bit per clock.
// Operands arrive on a valid/ready handshake; {C,S} leave on a second one.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a SUB port; SUB=1 gives A-B.
module serial_adder #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         SUB,
`endif
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] S,
    output logic         C
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_nxt;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;

    logic           sub_sel;
    logic           accept;
    logic           last_bit;
    logic           ha0_sum;
    logic           ha0_cry;
    logic           ha1_sum;
    logic           ha1_cry;
    logic           fa_cout;

    // Subtract select: inverted B plus a carry seed of one forms A - B.
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = SUB;
`else
    assign sub_sel = 1'b0;
`endif

    assign accept   = (state_q == IDLE) && IN_VALID;
    assign last_bit = (cnt_q == CW'(W - 1));

    // Full adder on the current LSBs: two half adders plus an OR.
    assign ha0_sum = a_q[0] ^ b_q[0];
    assign ha0_cry = a_q[0] & b_q[0];
    assign ha1_sum = ha0_sum ^ carry_q;
    assign ha1_cry = ha0_sum & carry_q;
    assign fa_cout = ha0_cry | ha1_cry;

    // Next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (IN_VALID)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (OUT_READY) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            S         <= '0;
            C         <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            IN_READY  <= (state_nxt == IDLE);
            OUT_VALID <= (state_nxt == DONE);
            if (accept) begin
                a_q     <= A;
                b_q     <= B ^ {W{sub_sel}};
                carry_q <= sub_sel;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                S       <= W'({ha1_sum, S} >> 1);
                a_q     <= a_q >> 1;
                b_q     <= b_q >> 1;
                carry_q <= fa_cout;
                cnt_q   <= cnt_q + CW'(1);
                if (last_bit) begin
                    C <= fa_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder against an arithmetic model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
    logic         SUB;
`endif
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] S;
    logic         C;

    int n_tests;
    int n_fail;
    bit chk_en;

    serial_adder #(.W(W)) dut (
        .CLK       (clk),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB       (SUB),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .C         (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: result is plain arithmetic, timing is a W-cycle countdown.
    logic         m_valid;
    int           m_left;
    bit           m_known;
    logic [W-1:0] m_s;
    logic         m_c;
    logic [W:0]   m_pend;

    function automatic logic [W:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    logic cur_sub;
`ifdef SERIAL_ADDER_SUB_EN
    assign cur_sub = SUB;
`else
    assign cur_sub = 1'b0;
`endif

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (RST) begin
            m_valid <= 1'b0;
            m_left  <= 0;
            m_known <= 1'b1;
            m_s     <= '0;
            m_c     <= 1'b0;
        end else if (m_valid) begin
            if (OUT_READY) m_valid <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_known <= 1'b1;
                m_s     <= m_pend[W-1:0];
                m_c     <= m_pend[W];
            end
        end else if (IN_VALID) begin
            m_pend  <= model_result(A, B, cur_sub);
            m_left  <= W;
            m_known <= 1'b0;
        end
    end

    // Compare DUT against model every cycle once out of reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_in_ready", 32'(IN_READY), 32'(!m_valid && m_left == 0));
            check("model_out_valid", 32'(OUT_VALID), 32'(m_valid));
            if (m_known) begin
                check("model_s", 32'(S), 32'(m_s));
                check("model_c", 32'(C), 32'(m_c));
            end
        end
    end

    // Present operands and return at the negedge after the acceptance edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit keep_valid);
        int n;
`ifdef SERIAL_ADDER_SUB_EN
        SUB = sub;
`else
        if (sub) $display("note: sub ignored in add-only build");
`endif
        A = a;
        B = b;
        IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!IN_READY) check("accept_timeout", 32'(n), 32'(0));
        @(negedge clk);
        if (!keep_valid) IN_VALID = 1'b0;
    endtask

    // Wait for the result, check latency and literal values, optionally stall.
    task automatic collect(input logic [W-1:0] exp_s, input logic exp_c, input int stall,
                           input bit keep_valid);
        int n;
        OUT_READY = (stall == 0);
        n = 0;
        while (!OUT_VALID && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("lit_s", 32'(S), 32'(exp_s));
        check("lit_c", 32'(C), 32'(exp_c));
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 32'(OUT_VALID), 32'(1));
            check("stall_ready", 32'(IN_READY), 32'(0));
            check("stall_s", 32'(S), 32'(exp_s));
            check("stall_c", 32'(C), 32'(exp_c));
            IN_VALID = (i % 2 == 0);
            @(negedge clk);
        end
        if (!keep_valid) IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        check("pre_hs_valid", 32'(OUT_VALID), 32'(1));
        @(negedge clk);
        check("post_hs_valid", 32'(OUT_VALID), 32'(0));
        check("post_hs_ready", 32'(IN_READY), 32'(1));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        chk_en    = 1'b0;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        A         = '0;
        B         = '0;
`ifdef SERIAL_ADDER_SUB_EN
        SUB       = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        RST = 1'b0;
        check("rst_in_ready", 32'(IN_READY), 32'(1));
        check("rst_out_valid", 32'(OUT_VALID), 32'(0));
        check("rst_s", 32'(S), 32'(0));
        check("rst_c", 32'(C), 32'(0));

        send(8'h00, 8'h00, 1'b0, 1'b0); collect(8'h00, 1'b0, 0, 1'b0);
        send(8'hFF, 8'h01, 1'b0, 1'b0); collect(8'h00, 1'b1, 0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 1'b0); collect(8'h00, 1'b1, 0, 1'b0);
        send(8'hA5, 8'h5A, 1'b0, 1'b0); collect(8'hFF, 1'b0, 5, 1'b0);

        // Held IN_VALID with operands switched after acceptance.
        send(8'h10, 8'h20, 1'b0, 1'b1);
        A = 8'h7F;
        B = 8'h7F;
        collect(8'h30, 1'b0, 0, 1'b1);
        @(negedge clk);
        IN_VALID = 1'b0;
        collect(8'hFE, 1'b0, 0, 1'b0);

        // Reset in the middle of RUN abandons the operation.
        send(8'hF0, 8'h0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check("midrst_valid", 32'(OUT_VALID), 32'(0));
        check("midrst_ready", 32'(IN_READY), 32'(1));
        check("midrst_s", 32'(S), 32'(0));
        check("midrst_c", 32'(C), 32'(0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abandon_no_valid", 32'(OUT_VALID), 32'(0));
        end
        send(8'h01, 8'h02, 1'b0, 1'b0); collect(8'h03, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        send(8'h05, 8'h07, 1'b1, 1'b0); collect(8'hFE, 1'b0, 0, 1'b0);
        send(8'h07, 8'h05, 1'b1, 1'b0); collect(8'h02, 1'b1, 0, 1'b0);
        send(8'h07, 8'h05, 1'b0, 1'b0); collect(8'h0C, 1'b0, 0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
